// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO controller bus.
// Groups the FIFO read port, the writer monitor tap, the downstream
// valid/ready stream and the occupancy status into one bundle.
//   master : environment side (writer tap, FIFO data, consumer ready)
//   slave  : controller side (read strobe, output stream, status)
interface fifo_read_ctrl_if #(
  parameter int width_data = 288,
  parameter int depth_log2 = 2
);
  logic                  write_en;
  logic                  read_en;
  logic [width_data-1:0] read_dt;
  logic                  out_valid;
  logic                  out_ready;
  logic [width_data-1:0] out_data;
  logic [depth_log2:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow_err;

  modport master (
    output write_en, read_dt, out_ready,
    input  read_en, out_valid, out_data, count, full, empty, overflow_err
  );

  modport slave (
    input  write_en, read_dt, out_ready,
    output read_en, out_valid, out_data, count, full, empty, overflow_err
  );
endinterface

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller for a small FIFO (address counter +
// SRAM with 1-cycle read latency).
// Tracks FIFO occupancy from the writer's strobe, issues read_en only when a
// word exists and the 2-entry output buffer has a free slot for it, and
// presents the buffered words as a valid/ready stream.
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   bus (slave)         write_en (monitor), read_en, read_dt, out_valid,
//                       out_ready, out_data, count, full, empty, overflow_err
module fifo_read_ctrl #(
  parameter int width_data = 288,
  parameter int depth_log2 = 2
) (
  input  logic            clk,
  input  logic            reset,
  fifo_read_ctrl_if.slave bus
);
  localparam logic [depth_log2:0] DepthC = (depth_log2+1)'(1 << depth_log2);

  logic [depth_log2:0]   count_q, count_d;
  logic                  pend_q, pend_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [width_data-1:0] buf0_q, buf0_d;   // head
  logic [width_data-1:0] buf1_q, buf1_d;
  logic                  ovf_q, ovf_d;

  logic full, empty, rd, wr_acc, pop, cap, out_valid;

  always_comb begin
    full      = (count_q == DepthC);
    empty     = (count_q == '0);
    out_valid = (buf_cnt_q != 2'd0);
    // Credit: words in flight plus words buffered never exceed 2, so every
    // capture lands in a free slot.
    rd        = !empty && (({1'b0, pend_q} + buf_cnt_q) < 2'd2);
    wr_acc    = bus.write_en && !full;
    pop       = out_valid && bus.out_ready;
    cap       = pend_q;
  end

  always_comb begin
    count_d = count_q + (depth_log2+1)'(wr_acc) - (depth_log2+1)'(rd);
    pend_d  = rd;
    ovf_d   = ovf_q | (bus.write_en & full);
  end

  // Output buffer: buf0 is the head; buf1 only ever holds the second word.
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    case ({pop, cap})
      2'b11: begin
        if (buf_cnt_q == 2'd2) begin
          buf0_d = buf1_q;
          buf1_d = bus.read_dt;
        end else begin
          buf0_d = bus.read_dt;
        end
      end
      2'b10: begin
        buf0_d    = buf1_q;
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b01: begin
        if (buf_cnt_q == 2'd0) buf0_d = bus.read_dt;
        else                   buf1_d = bus.read_dt;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      default: ;
    endcase
  end

  // Reset also drops any read in flight: read_dt returned the cycle after
  // reset is ignored because pend is cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      pend_q    <= 1'b0;
      buf_cnt_q <= 2'd0;
      buf0_q    <= '0;
      buf1_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      pend_q    <= pend_d;
      buf_cnt_q <= buf_cnt_d;
      buf0_q    <= buf0_d;
      buf1_q    <= buf1_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.read_en      = rd;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = buf0_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.overflow_err = ovf_q;
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a 4-entry SRAM FIFO environment feeds read_dt,
// and a queue-based reference model predicts every output each cycle.
module tb_fifo_read_ctrl;
  localparam int W = 288;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_read_ctrl_if #(.width_data(W), .depth_log2(2)) bus();

  fifo_read_ctrl #(.width_data(W), .depth_log2(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- FIFO environment (SRAM + pointers) ----------------
  logic [W-1:0] mem [4];
  logic [2:0]   wp, rp;
  logic [W-1:0] wdata;

  always @(posedge clk) begin
    if (bus.read_en) bus.read_dt <= mem[rp[1:0]];
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (bus.write_en && ((wp - rp) != 3'd4)) begin
        mem[wp[1:0]] <= wdata;
        wp <= wp + 3'd1;
      end
      if (bus.read_en) rp <= rp + 3'd1;
    end
  end

  // ---------------- reference model ----------------
  int           m_count;
  bit           m_infl;
  logic [W-1:0] m_infl_word;
  logic [W-1:0] m_fifo[$];   // words sitting in the FIFO, write order
  logic [W-1:0] m_buf[$];    // words visible to the consumer
  bit           m_ovf;

  int total = 0;
  int fails = 0;

  function automatic bit exp_rd();
    return (m_count > 0) && ((int'(m_infl) + m_buf.size()) < 2);
  endfunction

  task automatic model_update(input bit we, input logic [W-1:0] wd,
                              input bit rdy, input bit rst);
    bit rd;
    if (rst) begin
      m_count = 0; m_infl = 0; m_ovf = 0;
      m_fifo.delete(); m_buf.delete();
      return;
    end
    rd = exp_rd();
    if (m_buf.size() > 0 && rdy) void'(m_buf.pop_front());
    if (m_infl) m_buf.push_back(m_infl_word);
    if (rd) m_infl_word = m_fifo.pop_front();
    m_infl = rd;
    if (we && m_count == 4) m_ovf = 1;
    if (we && m_count < 4) begin
      m_fifo.push_back(wd);
      m_count++;
    end
    if (rd) m_count--;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare();
    chk("read_en", W'(bus.read_en), W'(exp_rd()));
    chk("out_valid", W'(bus.out_valid), W'(m_buf.size() != 0));
    if (m_buf.size() != 0) chk("out_data", bus.out_data, m_buf[0]);
    chk("count", W'(bus.count), W'(m_count));
    chk("full", W'(bus.full), W'(m_count == 4));
    chk("empty", W'(bus.empty), W'(m_count == 0));
    chk("overflow_err", W'(bus.overflow_err), W'(m_ovf));
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock: drive at negedge, advance model, check at next negedge.
  task automatic step(input bit we, input bit rdy, input bit rst);
    wdata         = rand_word();
    bus.write_en  = we;
    bus.out_ready = rdy;
    reset         = rst;
    model_update(we, wdata, rdy, rst);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  logic [W-1:0] d0;

  initial begin
    bus.write_en  = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    wdata         = '0;
    @(negedge clk);
    step(0, 0, 1);
    step(0, 0, 1);
    // reset state
    chk("rst_count", W'(bus.count), W'(0));
    chk("rst_read_en", W'(bus.read_en), W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_ovf", W'(bus.overflow_err), W'(0));

    // single word through an empty system
    step(1, 1, 0); d0 = wdata;
    chk("t1_read_en", W'(bus.read_en), W'(1));
    chk("t1_count1", W'(bus.count), W'(1));
    step(0, 1, 0);
    chk("t1_count0", W'(bus.count), W'(0));
    chk("t1_not_valid_yet", W'(bus.out_valid), W'(0));
    step(0, 1, 0);
    chk("t1_valid", W'(bus.out_valid), W'(1));
    chk("t1_data", bus.out_data, d0);
    step(0, 1, 0);
    chk("t1_popped", W'(bus.out_valid), W'(0));

    // 4 writes, consumer stalled: buffer holds 2, FIFO holds 2
    step(0, 0, 1);
    step(1, 0, 0); d0 = wdata;
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("t2_count", W'(bus.count), W'(2));
    chk("t2_full", W'(bus.full), W'(0));
    chk("t2_valid", W'(bus.out_valid), W'(1));
    chk("t2_head", bus.out_data, d0);
    chk("t2_no_read", W'(bus.read_en), W'(0));

    // fill and overflow
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t3_full", W'(bus.full), W'(1));
    chk("t3_count4", W'(bus.count), W'(4));
    chk("t3_no_ovf", W'(bus.overflow_err), W'(0));
    step(1, 0, 0);
    chk("t3_ovf", W'(bus.overflow_err), W'(1));
    chk("t3_count_sat", W'(bus.count), W'(4));
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("t3_ovf_sticky", W'(bus.overflow_err), W'(1));
    chk("t3_drained", W'(bus.count), W'(0));

    // continuous streaming
    step(0, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    chk("t4_drained_valid", W'(bus.out_valid), W'(0));

    // random traffic with stalls
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 99) < 55), ((i % 2) == 0) && ($urandom_range(0, 3) != 0), 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);

    // reset while a read is in flight: the returning data must be dropped
    step(0, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("t6_pre_read_en", W'(bus.read_en), W'(1));
    step(0, 0, 1);
    chk("t6_valid", W'(bus.out_valid), W'(0));
    chk("t6_count", W'(bus.count), W'(0));
    chk("t6_read_en", W'(bus.read_en), W'(0));
    step(0, 1, 0);
    chk("t6_stale_ignored", W'(bus.out_valid), W'(0));
    step(0, 1, 0);
    chk("t6_still_empty", W'(bus.out_valid), W'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
